// File: rtl/pcap_dma_reader_if.sv
// AXI3 read-address/read-data channels plus the 32-bit playback stream of the PCAP read DMA.
interface pcap_dma_reader_if;
   logic [31:0] m_axi_araddr;
   logic [3:0]  m_axi_arlen;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;

   modport master (
      output m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready, dout, dout_valid,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, dout_ready
   );

   modport slave (
      input  m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready, dout, dout_valid,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, dout_ready
   );
endinterface

// File: rtl/pcap_dma_reader.sv
// AXI3 read DMA: fetches 64-byte bursts of host-memory blocks into a FWFT FIFO and streams them out.
// state  | meaning
// IDLE   | no block active; waits for start with a queued address
// ISSUE  | waits for FIFO credit, then presents one read burst address
// DATA   | accepts the burst's beats into the FIFO
// DRAIN  | soft reset seen mid-burst; finishes the burst and discards its beats
module pcap_dma_reader #(
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          dma_reset_i,
   input  logic                          dma_start_i,
   input  logic [31:0]                   dma_addr_i,
   input  logic                          dma_addr_wstb_i,
   input  logic [31:0]                   block_size_i,
   output logic                          busy_o,
   output logic                          irq_o,
   output logic [3:0]                    irq_status_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   pcap_dma_reader_if.master             bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;
   localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0] BURST_L = (AW + 1)'(BURST_LEN);

   logic [1:0]  r_state;
   logic [31:0] r_slot_addr;
   logic        r_slot_valid;
   logic [31:0] r_cur_addr;
   logic [31:0] r_remaining;
   logic        r_arvalid;
   logic        r_ovr;
   logic        r_err;
   logic        r_irq;
   logic [3:0]  r_irq_status;
   logic [31:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   logic [AW:0] w_level;
   logic        w_credit;
   logic        w_rready;
   logic        w_beat;
   logic        w_rlast;
   logic        w_rresp_err;
   logic        w_err;
   logic        w_ar_hs;
   logic        w_push;
   logic        w_pop;
   logic        w_dout_valid;
   logic        w_start_take;
   logic        w_reload_take;
   logic        w_slot_take;
   logic [31:0] w_addr_aligned;

   assign w_level        = r_wr_ptr - r_rd_ptr;
   assign w_credit       = (DEPTH_L - w_level) >= BURST_L;
   assign w_rready       = (r_state == S_DATA) || (r_state == S_DRAIN);
   assign w_beat         = bus.m_axi_rvalid && w_rready;
   assign w_rlast        = w_beat && bus.m_axi_rlast;
   assign w_rresp_err    = w_beat && (bus.m_axi_rresp != 2'b00);
   assign w_err          = r_err || w_rresp_err;
   assign w_ar_hs        = r_arvalid && bus.m_axi_arready;
   assign w_push         = (r_state == S_DATA) && bus.m_axi_rvalid && !dma_reset_i;
   assign w_dout_valid   = (w_level != '0);
   assign w_pop          = w_dout_valid && bus.dout_ready && !dma_reset_i;
   assign w_addr_aligned = dma_addr_i & 32'hFFFF_FFC0;

   assign w_start_take  = (r_state == S_IDLE) && dma_start_i && r_slot_valid && !dma_reset_i;
   assign w_reload_take = (r_state == S_DATA) && !dma_reset_i && w_rlast && !w_err &&
                          (r_remaining == 32'd0) && r_slot_valid;
   assign w_slot_take   = w_start_take || w_reload_take;

   assign busy_o           = (r_state != S_IDLE);
   assign irq_o            = r_irq;
   assign irq_status_o     = r_irq_status;
   assign fifo_level_o     = w_level;
   assign bus.m_axi_araddr  = r_cur_addr;
   assign bus.m_axi_arlen   = 4'(BURST_LEN - 1);
   assign bus.m_axi_arvalid = r_arvalid;
   assign bus.m_axi_rready  = w_rready;
   assign bus.dout_valid    = w_dout_valid;
   assign bus.dout          = w_dout_valid ? r_mem[r_rd_ptr[AW-1:0]] : 32'd0;

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.m_axi_rdata;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (dma_reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state      <= S_IDLE;
         r_slot_addr  <= '0;
         r_slot_valid <= 1'b0;
         r_cur_addr   <= '0;
         r_remaining  <= '0;
         r_arvalid    <= 1'b0;
         r_ovr        <= 1'b0;
         r_err        <= 1'b0;
         r_irq        <= 1'b0;
         r_irq_status <= '0;
      end else begin
         r_irq        <= 1'b0;
         r_irq_status <= '0;
         case (r_state)
            S_IDLE: begin
               if (dma_start_i && !dma_reset_i) begin
                  if (r_slot_valid) begin
                     r_cur_addr  <= r_slot_addr;
                     r_remaining <= block_size_i;
                     r_state     <= S_ISSUE;
                  end else begin
                     r_irq        <= 1'b1;
                     r_irq_status <= 4'b0110;
                     r_ovr        <= 1'b0;
                  end
               end
            end
            S_ISSUE: begin
               if (r_arvalid) begin
                  if (bus.m_axi_arready) begin
                     r_arvalid   <= 1'b0;
                     r_cur_addr  <= r_cur_addr + BURST_BYTES;
                     r_remaining <= r_remaining - BURST_BYTES;
                  end
                  // An address already on the bus must complete, so its burst is drained.
                  if (dma_reset_i)            r_state <= S_DRAIN;
                  else if (bus.m_axi_arready) r_state <= S_DATA;
               end else if (dma_reset_i) begin
                  r_state <= S_IDLE;
               end else if (w_credit) begin
                  r_arvalid <= 1'b1;
               end
            end
            S_DATA: begin
               if (dma_reset_i) begin
                  r_state <= w_rlast ? S_IDLE : S_DRAIN;
               end else begin
                  if (w_rresp_err) r_err <= 1'b1;
                  if (w_rlast) begin
                     if (w_err) begin
                        r_irq        <= 1'b1;
                        r_irq_status <= {1'b1, r_ovr, 2'b00};
                        r_err        <= 1'b0;
                        r_ovr        <= 1'b0;
                        r_state      <= S_IDLE;
                     end else if (r_remaining != 32'd0) begin
                        r_state <= S_ISSUE;
                     end else if (r_slot_valid) begin
                        r_irq        <= 1'b1;
                        r_irq_status <= {1'b0, r_ovr, 2'b01};
                        r_ovr        <= 1'b0;
                        r_cur_addr   <= r_slot_addr;
                        r_remaining  <= block_size_i;
                        r_state      <= S_ISSUE;
                     end else begin
                        r_irq        <= 1'b1;
                        r_irq_status <= {1'b0, r_ovr, 2'b11};
                        r_ovr        <= 1'b0;
                        r_state      <= S_IDLE;
                     end
                  end
               end
            end
            default: begin
               if (w_ar_hs) r_arvalid <= 1'b0;
               if (w_rlast && !r_arvalid) r_state <= S_IDLE;
            end
         endcase

         // Slot and sticky updates come last so a same-cycle overrun survives the irq that clears it.
         if (dma_reset_i) begin
            r_slot_valid <= 1'b0;
            r_ovr        <= 1'b0;
            r_err        <= 1'b0;
         end else begin
            if (w_slot_take) r_slot_valid <= 1'b0;
            if (dma_addr_wstb_i) begin
               if (!r_slot_valid || w_slot_take) begin
                  r_slot_addr  <= w_addr_aligned;
                  r_slot_valid <= 1'b1;
               end else begin
                  r_ovr <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_pcap_dma_reader.sv
// Directed bench for pcap_dma_reader: AXI read slave model, stream consumer and irq/credit monitors.
module tb_pcap_dma_reader;
   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        dma_reset_i = 1'b0;
   logic        dma_start_i = 1'b0;
   logic [31:0] dma_addr_i = '0;
   logic        dma_addr_wstb_i = 1'b0;
   logic [31:0] block_size_i = 32'd256;
   logic        busy_o;
   logic        irq_o;
   logic [3:0]  irq_status_o;
   logic [6:0]  fifo_level_o;

   always #5 clk_i = ~clk_i;

   pcap_dma_reader_if bus ();

   pcap_dma_reader #(.BURST_LEN(16), .FIFO_DEPTH(64)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .dma_reset_i     (dma_reset_i),
      .dma_start_i     (dma_start_i),
      .dma_addr_i      (dma_addr_i),
      .dma_addr_wstb_i (dma_addr_wstb_i),
      .block_size_i    (block_size_i),
      .busy_o          (busy_o),
      .irq_o           (irq_o),
      .irq_status_o    (irq_status_o),
      .fifo_level_o    (fifo_level_o),
      .bus             (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] bsize;
      logic [31:0] exp_base;
      logic [3:0]  exp_irq;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int credit_viol = 0;
   int rready_viol = 0;
   int level_viol = 0;
   int arlen_viol = 0;
   int rwait_viol = 0;
   int beat_cnt = 0;
   int err_beat = 0;
   bit err_en = 1'b0;
   bit slave_abort = 1'b0;
   bit mon_en = 1'b1;

   logic [31:0] ar_q[$];
   logic [31:0] out_q[$];
   logic [3:0]  irq_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_ar_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_addr(input logic [31:0] a);
      dma_addr_i = a;
      dma_addr_wstb_i = 1'b1;
      tick();
      dma_addr_wstb_i = 1'b0;
   endtask

   task automatic pulse_start();
      dma_start_i = 1'b1;
      tick();
      dma_start_i = 1'b0;
   endtask

   task automatic clear_logs();
      ar_q.delete();
      out_q.delete();
      irq_q.delete();
      exp_q.delete();
      exp_ar_q.delete();
   endtask

   task automatic add_exp(input logic [31:0] base, input logic [31:0] bytes);
      for (int k = 0; k < int'(bytes / 4); k++) exp_q.push_back((base >> 2) + 32'(k));
      for (int k = 0; k < int'(bytes / 64); k++) exp_ar_q.push_back(base + 32'(64 * k));
   endtask

   task automatic expect_irq(input string name, input logic [3:0] exp);
      int n = 0;
      while (irq_q.size() == 0 && n < 5000) begin
         tick();
         n++;
      end
      if (irq_q.size() == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
      else chk(name, 32'(irq_q.pop_front()), 32'(exp));
   endtask

   task automatic wait_words(input int n);
      int t = 0;
      while (out_q.size() < n && t < 5000) begin
         tick();
         t++;
      end
      repeat (3) tick();
   endtask

   task automatic check_stream(input string name);
      int bad = 0;
      chk({name, "_words"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < out_q.size(); k++)
         if (out_q[k] !== exp_q[k]) bad++;
      chk({name, "_data_bad"}, 32'(bad), 32'd0);
   endtask

   task automatic check_ars(input string name);
      int bad = 0;
      chk({name, "_ar_count"}, 32'(ar_q.size()), 32'(exp_ar_q.size()));
      for (int k = 0; k < exp_ar_q.size() && k < ar_q.size(); k++)
         if (ar_q[k] !== exp_ar_q[k]) bad++;
      chk({name, "_ar_bad"}, 32'(bad), 32'd0);
   endtask

   task automatic run_block(input string name, input vec_t v);
      clear_logs();
      add_exp(v.exp_base, v.bsize);
      block_size_i = v.bsize;
      write_addr(v.addr);
      pulse_start();
      expect_irq({name, "_irq"}, v.exp_irq);
      wait_words(int'(v.bsize / 4));
      check_stream(name);
      check_ars(name);
      chk({name, "_busy"}, 32'(busy_o), 32'd0);
      chk({name, "_level"}, 32'(fifo_level_o), 32'd0);
   endtask

   always @(negedge clk_i) begin
      if (mon_en) begin
         if (irq_o) irq_q.push_back(irq_status_o);
         if (bus.dout_valid && bus.dout_ready) out_q.push_back(bus.dout);
         if (bus.m_axi_arvalid && (64 - int'(fifo_level_o)) < 16) credit_viol++;
         if (bus.m_axi_rvalid && !bus.m_axi_rready) rready_viol++;
         if (int'(fifo_level_o) > 64) level_viol++;
      end
   end

   initial begin : axi_slave
      logic [31:0] a_cur;
      int wait_cnt;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rvalid  = 1'b0;
      bus.m_axi_rdata   = '0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rlast   = 1'b0;
      forever begin
         @(negedge clk_i);
         if (bus.m_axi_arvalid && !reset_i && !slave_abort) begin
            a_cur = bus.m_axi_araddr;
            ar_q.push_back(a_cur);
            if (bus.m_axi_arlen !== 4'd15) arlen_viol++;
            bus.m_axi_arready = 1'b1;
            tick();
            bus.m_axi_arready = 1'b0;
            for (int b = 0; b < 16 && !slave_abort; b++) begin
               bus.m_axi_rvalid = 1'b1;
               bus.m_axi_rdata  = {2'b00, a_cur[31:2]} + 32'(b);
               bus.m_axi_rlast  = (b == 15);
               bus.m_axi_rresp  = (err_en && b == err_beat) ? 2'b10 : 2'b00;
               wait_cnt = 0;
               @(negedge clk_i);
               while (!bus.m_axi_rready && !slave_abort && wait_cnt < 1000) begin
                  @(negedge clk_i);
                  wait_cnt++;
               end
               if (wait_cnt >= 1000) rwait_viol++;
               tick();
               beat_cnt++;
            end
            err_en = 1'b0;
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rlast  = 1'b0;
            bus.m_axi_rresp  = 2'b00;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : test
      vec_t vecs[4];
      int b0;
      int n;
      vecs[0] = '{32'h1000_0000, 32'd256, 32'h1000_0000, 4'b0011};
      vecs[1] = '{32'h2000_0040, 32'd64,  32'h2000_0040, 4'b0011};
      vecs[2] = '{32'h1000_007F, 32'd64,  32'h1000_0040, 4'b0011};
      vecs[3] = '{32'h3000_0FC0, 32'd128, 32'h3000_0FC0, 4'b0011};
      bus.dout_ready = 1'b1;

      #3;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_status", 32'(irq_status_o), 32'd0);
      chk("rst_level", 32'(fifo_level_o), 32'd0);
      chk("rst_arvalid", 32'(bus.m_axi_arvalid), 32'd0);
      chk("rst_araddr", bus.m_axi_araddr, 32'd0);
      chk("rst_rready", 32'(bus.m_axi_rready), 32'd0);
      chk("rst_dvalid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout", bus.dout, 32'd0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      tick();

      // Start with an empty address slot.
      clear_logs();
      pulse_start();
      expect_irq("empty_irq", 4'b0110);
      repeat (5) tick();
      chk("empty_busy", 32'(busy_o), 32'd0);
      chk("empty_ar", 32'(ar_q.size()), 32'd0);

      for (int i = 0; i < 4; i++) run_block($sformatf("vec%0d", i), vecs[i]);

      // Double buffer: B queued while A is in flight.
      clear_logs();
      block_size_i = 32'd128;
      add_exp(32'h1000_0000, 32'd128);
      add_exp(32'h1000_0100, 32'd128);
      write_addr(32'h1000_0000);
      pulse_start();
      write_addr(32'h1000_0100);
      expect_irq("dbuf_irq1", 4'b0001);
      expect_irq("dbuf_irq2", 4'b0011);
      wait_words(64);
      check_stream("dbuf");
      check_ars("dbuf");
      chk("dbuf_busy", 32'(busy_o), 32'd0);

      // Address overrun: second write ignored, first block reports bit 2.
      clear_logs();
      block_size_i = 32'd64;
      add_exp(32'h7000_0000, 32'd64);
      write_addr(32'h7000_0000);
      write_addr(32'h7100_0000);
      pulse_start();
      expect_irq("ovr_irq", 4'b0111);
      wait_words(16);
      check_stream("ovr");
      check_ars("ovr");
      clear_logs();
      pulse_start();
      expect_irq("ovr_dropped_irq", 4'b0110);
      repeat (5) tick();
      chk("ovr_dropped_ar", 32'(ar_q.size()), 32'd0);
      run_block("ovr_clear", '{32'h7200_0000, 32'd64, 32'h7200_0000, 4'b0011});

      // Backpressure: consumer stalled, credit gating must stop at a full FIFO.
      clear_logs();
      bus.dout_ready = 1'b0;
      block_size_i = 32'd512;
      add_exp(32'h4000_0000, 32'd512);
      write_addr(32'h4000_0000);
      pulse_start();
      repeat (2000) tick();
      chk("bp_level", 32'(fifo_level_o), 32'd64);
      chk("bp_ar_count", 32'(ar_q.size()), 32'd4);
      chk("bp_busy", 32'(busy_o), 32'd1);
      chk("bp_no_irq", 32'(irq_q.size()), 32'd0);
      chk("bp_no_out", 32'(out_q.size()), 32'd0);
      bus.dout_ready = 1'b1;
      expect_irq("bp_irq", 4'b0011);
      wait_words(128);
      check_stream("bp");
      check_ars("bp");

      // AXI error on beat 5 of the first burst.
      clear_logs();
      err_en = 1'b1;
      err_beat = 5;
      b0 = beat_cnt;
      block_size_i = 32'd256;
      add_exp(32'h5000_0000, 32'd64);
      write_addr(32'h5000_0000);
      pulse_start();
      expect_irq("err_irq", 4'b1000);
      repeat (100) tick();
      check_stream("err");
      check_ars("err");
      chk("err_beats", 32'(beat_cnt - b0), 32'd16);
      chk("err_busy", 32'(busy_o), 32'd0);

      // Soft reset after beat 3 of a burst.
      clear_logs();
      bus.dout_ready = 1'b0;
      b0 = beat_cnt;
      block_size_i = 32'd256;
      write_addr(32'h6000_0000);
      pulse_start();
      n = 0;
      while (beat_cnt - b0 < 3 && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      chk("srst_pre_level", 32'(fifo_level_o), 32'd3);
      dma_reset_i = 1'b1;
      tick();
      dma_reset_i = 1'b0;
      @(negedge clk_i);
      chk("srst_level", 32'(fifo_level_o), 32'd0);
      chk("srst_dvalid", 32'(bus.dout_valid), 32'd0);
      chk("srst_busy_drain", 32'(busy_o), 32'd1);
      chk("srst_rready", 32'(bus.m_axi_rready), 32'd1);
      n = 0;
      while (beat_cnt - b0 < 16 && n < 500) begin
         @(negedge clk_i);
         n++;
      end
      repeat (2) tick();
      chk("srst_busy_after", 32'(busy_o), 32'd0);
      chk("srst_no_irq", 32'(irq_q.size()), 32'd0);
      chk("srst_ar_count", 32'(ar_q.size()), 32'd1);
      chk("srst_level_after", 32'(fifo_level_o), 32'd0);
      chk("srst_no_out", 32'(out_q.size()), 32'd0);
      bus.dout_ready = 1'b1;

      chk("credit_viol", 32'(credit_viol), 32'd0);
      chk("rready_viol", 32'(rready_viol), 32'd0);
      chk("level_viol", 32'(level_viol), 32'd0);
      chk("arlen_viol", 32'(arlen_viol), 32'd0);
      chk("rwait_viol", 32'(rwait_viol), 32'd0);

      // Async reset in the middle of a stream.
      clear_logs();
      block_size_i = 32'd256;
      write_addr(32'h6100_0000);
      pulse_start();
      n = 0;
      while (out_q.size() < 10 && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      chk("arst_streaming", 32'(out_q.size() >= 10), 32'd1);
      #2;
      mon_en = 1'b0;
      slave_abort = 1'b1;
      reset_i = 1'b1;
      #1;
      chk("arst_busy", 32'(busy_o), 32'd0);
      chk("arst_irq", 32'(irq_o), 32'd0);
      chk("arst_level", 32'(fifo_level_o), 32'd0);
      chk("arst_arvalid", 32'(bus.m_axi_arvalid), 32'd0);
      chk("arst_araddr", bus.m_axi_araddr, 32'd0);
      chk("arst_rready", 32'(bus.m_axi_rready), 32'd0);
      chk("arst_dvalid", 32'(bus.dout_valid), 32'd0);
      chk("arst_dout", bus.dout, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pcap_dma_reader.md
Name: pcap_dma_reader

Overview:
- AXI3 read-DMA engine; the reverse direction of the PCAP capture DMA.
- Fetches host-memory blocks into an internal FIFO and streams 32-bit words to a fabric consumer (table/sequence playback).
- Uses the same double-buffered address handshake as capture: address, start, next address. Raises an IRQ per completed block.
- Sits between the HP0 AXI port and the playback function blocks; driven by DRV-space registers.

Parameters:
BURST_LEN, 16, beats per AXI3 read burst (32-bit beats, 64 bytes)
FIFO_DEPTH, 64, output FIFO depth in words (power of two, >= 2*BURST_LEN)

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
dma_reset_i  in  1  soft-reset pulse: abort and flush
dma_start_i  in  1  pulse: begin reading from the queued address
dma_addr_i  in  32  block base byte address; bits [5:0] ignored (forced 0)
dma_addr_wstb_i  in  1  pulse: queue dma_addr_i as the next block address
block_size_i  in  32  bytes per block; multiple of 64, >= 64; sampled at each block start
busy_o  out  1  engine active (state != IDLE)
irq_o  out  1  one-cycle interrupt pulse
irq_status_o  out  4  [0] block done, [1] stream end, [2] addr overrun, [3] AXI error; valid while irq_o = 1
m_axi_araddr  out  32  burst address
m_axi_arlen  out  4  BURST_LEN-1
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address accept
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  data valid
m_axi_rready  out  1  data accept
dout_o  out  32  stream data
dout_valid_o  out  1  stream valid
dout_ready_i  in  1  stream accept
fifo_level_o  out  7  FIFO occupancy, 0..FIFO_DEPTH

Behaviour:
- Reset values: all outputs 0; FIFO empty; next-address slot empty; state IDLE.
- Address slot (1 entry):
  - dma_addr_wstb_i with slot empty: load address, set slot valid.
  - Slot already valid: write ignored; addr-overrun sticky set, reported with the next irq, then cleared.
- States:
  - IDLE: on dma_start_i with slot valid, cur_addr <= slot, slot cleared, remaining <= block_size_i, go ISSUE. Start with slot empty: irq with status 0b0110, stay IDLE.
  - ISSUE: wait for credit, i.e. FIFO_DEPTH - fifo_level >= BURST_LEN. Then assert arvalid with araddr = cur_addr and hold it stable until arready. On handshake: cur_addr += 64, remaining -= 64, go DATA.
  - DATA: rready = 1 (space guaranteed by credit). Each rvalid beat is written to the FIFO. Non-zero rresp sets the error sticky. On rlast:
    - error sticky set: irq 0b1000 (plus overrun bit if set), go IDLE.
    - remaining != 0: go ISSUE.
    - remaining == 0 and slot valid: irq 0b0001, reload from slot and block_size_i, go ISSUE.
    - remaining == 0 and slot empty: irq 0b0011, go IDLE.
  - DRAIN: entered from DATA on dma_reset_i, or from ISSUE if arvalid is asserted but not yet accepted. In DRAIN:
    - arvalid held until accepted.
    - rready = 1; beats discarded until rlast, then IDLE.
    - No irq.
- One burst outstanding at a time. No 4 KB crossing is possible, since addresses are 64-byte aligned.
- FIFO:
  - First-word-fall-through; dout_valid_o rises the cycle after the first beat is written.
  - Simultaneous push and pop leaves the level unchanged.
  - Full is never reached by a write, because of credit gating.
- dma_reset_i in any state:
  - FIFO flushed, slot cleared, stickies cleared, dout_valid_o 0 next cycle.
  - IDLE or ISSUE without arvalid: go IDLE immediately.
- dma_start_i while busy_o = 1: ignored.
- irq_o is one cycle only, and is never asserted on the same cycle as reset.

Test Plan:
- Single block: BLOCK_SIZE=256, addr 0x1000_0000, start, no next addr, memory = incrementing words, consumer always ready. Expect 4 AR bursts at 0x1000_0000/40/80/C0 with arlen=15, 64 words 0..63 on dout, one irq with status 0b0011, busy_o low after.
- Double buffer: addr A=0x1000_0000, start, addr B=0x1000_0100, BLOCK_SIZE=128. Expect irq 0b0001 after 32 words, then 0x1000_0100 fetched, then irq 0b0011 after 64 total words in order.
- Backpressure: dout_ready_i low for 2000 cycles, FIFO_DEPTH=64. Expect fifo_level_o to settle at 64, no AR issued while credit < 16, no data lost or duplicated after release.
- Overrun/underflow: start with empty slot -> irq 0b0110. Two address writes before start -> second ignored, first block's irq carries bit 2.
- AXI error: rresp=2'b10 on beat 5 of the first burst -> all 16 beats still accepted, irq 0b1000, IDLE, no further AR.
- Reset mid-burst: dma_reset_i after beat 3 of a burst -> rready stays high until rlast, FIFO empty, no irq, busy_o low after rlast. Async reset_i asserted mid-stream -> all outputs 0 immediately.
